// File: rtl/ascii_operand_parser.sv
// ASCII line parser: N_OPS signed decimal operands per line, published atomically
// as one frame, or one coded error per malformed line.
//
// state   | meaning
// IDLE    | between operands, waiting for sign/digit/terminator
// SIGN    | '-' seen, first digit required
// DIGIT   | accumulating operand magnitude
// DISCARD | error raised, dropping bytes until terminator
module ascii_operand_parser #(
  parameter int N_OPS      = 4,
  parameter int W          = 4,
  parameter int MAX_DIGITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [N_OPS*W-1:0] ops,
  output logic               ops_valid,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               busy
);

  localparam int MW = $clog2(10**MAX_DIGITS) + 1;
  localparam int CW = ((MW > W) ? MW : W) + 1;
  localparam int IW = $clog2(N_OPS + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);

  localparam logic [CW-1:0] LIM_NEG = CW'(1) << (W - 1);
  localparam logic [CW-1:0] LIM_POS = LIM_NEG - CW'(1);

  localparam logic [1:0] E_BADCHAR = 2'd0;
  localparam logic [1:0] E_DIGITS  = 2'd1;
  localparam logic [1:0] E_RANGE   = 2'd2;
  localparam logic [1:0] E_COUNT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SIGN,
    S_DIGIT,
    S_DISCARD
  } state_t;

  state_t             state, state_nx;
  logic [IW-1:0]      idx, idx_nx, idx_t;
  logic [DW-1:0]      dcnt, dcnt_nx;
  logic [CW-1:0]      mag, mag_nx, mag_acc, sval;
  logic               neg, neg_nx;
  logic [N_OPS*W-1:0] slots, slots_nx;
  logic [N_OPS*W-1:0] ops_nx;
  logic               ops_valid_nx, err_nx;
  logic [1:0]         err_code_nx;

  logic is_digit, is_minus, is_delim, is_term, over;
  logic take_digit, do_commit, do_term, do_err;
  logic [1:0] code;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_minus = (rx_data == 8'h2D);
  assign is_delim = (rx_data == 8'h20) || (rx_data == 8'h2C);
  assign is_term  = (rx_data == 8'h0A) || (rx_data == 8'h0D);

  // Only DIGIT accumulates; SIGN/IDLE start from zero. mag < 10^(MAX_DIGITS-1) here,
  // so the product never wraps at CW bits.
  assign mag_acc = ((state == S_DIGIT) ? (mag * CW'(10)) : '0) + CW'(rx_data[3:0]);
  assign over    = mag_acc > (neg ? LIM_NEG : LIM_POS);
  assign sval    = neg ? (-mag) : mag;

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    dcnt_nx      = dcnt;
    mag_nx       = mag;
    neg_nx       = neg;
    slots_nx     = slots;
    ops_nx       = ops;
    ops_valid_nx = 1'b0;
    err_nx       = 1'b0;
    err_code_nx  = err_code;
    take_digit   = 1'b0;
    do_commit    = 1'b0;
    do_term      = 1'b0;
    do_err       = 1'b0;
    code         = E_BADCHAR;
    idx_t        = idx;

    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_digit) take_digit = 1'b1;
          else if (is_minus) begin
            neg_nx   = 1'b1;
            state_nx = S_SIGN;
          end
          else if (is_term) do_term = 1'b1;
          else if (!is_delim) do_err = 1'b1;
        end
        S_SIGN: begin
          if (is_digit) take_digit = 1'b1;
          else do_err = 1'b1;
        end
        S_DIGIT: begin
          if (is_digit) take_digit = 1'b1;
          else if (is_delim) do_commit = 1'b1;
          else if (is_term) begin
            do_commit = 1'b1;
            do_term   = 1'b1;
          end
          else do_err = 1'b1;
        end
        S_DISCARD: begin
          if (is_term) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    if (take_digit) begin
      if ((state == S_DIGIT) && (dcnt == DW'(MAX_DIGITS))) begin
        do_err = 1'b1;
        code   = E_DIGITS;
      end
      else if (over) begin
        do_err = 1'b1;
        code   = E_RANGE;
      end
      else begin
        mag_nx   = mag_acc;
        dcnt_nx  = dcnt + DW'(1);
        state_nx = S_DIGIT;
      end
    end

    if (do_commit) begin
      if (idx == IW'(N_OPS)) begin
        do_err = 1'b1;
        code   = E_COUNT;
      end
      else begin
        slots_nx[int'(idx)*W +: W] = sval[W-1:0];
        idx_t    = idx + IW'(1);
        idx_nx   = idx_t;
        neg_nx   = 1'b0;
        mag_nx   = '0;
        dcnt_nx  = '0;
        state_nx = S_IDLE;
      end
    end

    // Terminator rule uses the index after any same-byte commit.
    if (do_term && !do_err) begin
      if (idx_t == IW'(N_OPS)) begin
        ops_nx       = slots_nx;
        ops_valid_nx = 1'b1;
        idx_nx       = '0;
        state_nx     = S_IDLE;
      end
      else if (idx_t != '0) begin
        do_err = 1'b1;
        code   = E_COUNT;
      end
    end

    // An error raised on the terminator itself has already ended the line.
    if (do_err) begin
      err_nx      = 1'b1;
      err_code_nx = code;
      idx_nx      = '0;
      neg_nx      = 1'b0;
      mag_nx      = '0;
      dcnt_nx     = '0;
      state_nx    = is_term ? S_IDLE : S_DISCARD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      dcnt      <= '0;
      mag       <= '0;
      neg       <= 1'b0;
      slots     <= '0;
      ops       <= '0;
      ops_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= E_BADCHAR;
    end
    else begin
      state     <= state_nx;
      idx       <= idx_nx;
      dcnt      <= dcnt_nx;
      mag       <= mag_nx;
      neg       <= neg_nx;
      slots     <= slots_nx;
      ops       <= ops_nx;
      ops_valid <= ops_valid_nx;
      err       <= err_nx;
      err_code  <= err_code_nx;
    end
  end

  assign busy = (state != S_IDLE) || (idx != '0);

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Scoreboard bench for ascii_operand_parser: expected frame/error pulses are queued
// when the triggering byte is driven and matched when the DUT pulses.
module tb_ascii_operand_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] ops;
  logic        ops_valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    bit          is_err;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_ops  = '0;
  logic [1:0]  exp_code = '0;

  ascii_operand_parser #(.N_OPS(4), .W(4), .MAX_DIGITS(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .ops       (ops),
    .ops_valid (ops_valid),
    .err       (err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
        chk("pulse_missing", 32'(sb[0].due), 32'(cyc));
        void'(sb.pop_front());
      end
      chk("pulse_exclusive", 32'(ops_valid & err), 32'd0);
      if (ops_valid || err) begin
        if (sb.size() == 0) begin
          chk("pulse_unexpected", {30'd0, ops_valid, err}, 32'd0);
        end
        else begin
          e = sb.pop_front();
          chk("pulse_time", 32'(cyc), 32'(e.due));
          chk("pulse_kind", 32'(err), 32'(e.is_err));
          if (e.is_err) begin
            chk("err_code", 32'(err_code), 32'(e.val));
            exp_code = e.val[1:0];
          end
          else begin
            chk("ops", 32'(ops), 32'(e.val));
            exp_ops = e.val;
          end
        end
      end
      chk("ops_hold", 32'(ops), 32'(exp_ops));
      chk("err_code_hold", 32'(err_code), 32'(exp_code));
    end
  end

  // ev_pos: index of the byte that should produce the pulse (-1 for none).
  task automatic send_line(input string s, input int ev_pos, input bit is_err,
                           input logic [15:0] val, input bit gaps, input bit complete);
    bit starts_operand;
    starts_operand = (s[0] == 8'h2D) || ((s[0] >= 8'h30) && (s[0] <= 8'h39));
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(negedge clk);
          rx_valid = 1'b0;
          rx_data  = 8'hxx;
        end
      end
      @(negedge clk);
      if (i == 1 && starts_operand) chk("busy_mid", 32'(busy), 32'd1);
      rx_valid = 1'b1;
      rx_data  = s[i];
      if (i == ev_pos) sb.push_back('{due: cyc + 1, is_err: is_err, val: val});
    end
    @(negedge clk);
    rx_valid = 1'b0;
    if (complete) chk("busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    chk("rst_ops", 32'(ops), 32'd0);
    chk("rst_ops_valid", 32'(ops_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    send_line("1 -2 3 -4\n",   9, 1'b0, 16'hC3E1, 1'b0, 1'b1);
    send_line("7,-8,,0 5\r\n", 9, 1'b0, 16'h5087, 1'b1, 1'b1);
    send_line("8 1 2 3\n",     0, 1'b1, 16'd2,    1'b0, 1'b1);
    send_line("-8 0 0 0\n",    8, 1'b0, 16'h0008, 1'b0, 1'b1);
    send_line("007 1 1 1\n",   2, 1'b1, 16'd1,    1'b1, 1'b1);
    send_line("1 - 2 3 4\n",   3, 1'b1, 16'd0,    1'b0, 1'b1);
    send_line("1 2 3\n",       5, 1'b1, 16'd3,    1'b0, 1'b1);
    send_line("1 2 3 4 5\n",   9, 1'b1, 16'd3,    1'b1, 1'b1);
    send_line("\r\n",         -1, 1'b0, 16'd0,    1'b0, 1'b1);
    send_line("-8,7,-1,1\n",   9, 1'b0, 16'h1F78, 1'b1, 1'b1);

    send_line("1 2 ",         -1, 1'b0, 16'd0,    1'b0, 1'b0);
    chk("busy_partial", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ops", 32'(ops), 32'd0);
    chk("arst_ops_valid", 32'(ops_valid), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_err_code", 32'(err_code), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    exp_ops  = '0;
    exp_code = '0;
    @(negedge clk);
    reset = 1'b1;

    send_line("3 3 3 3\n",     7, 1'b0, 16'h3333, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascii_operand_parser.md
# ascii_operand_parser

Parametrised receive-side front end for the UART math path. Consumes the byte stream from the UART rx FIFO and parses a line of `N_OPS` signed multi-digit decimal operands separated by delimiters. It presents the whole frame atomically to the arithmetic core, or flags one coded error per malformed line. It replaces the single-digit, fixed-four-operand capture logic and adds delimiters, multi-digit values, range checking and line resynchronisation.

## Interface
- `N_OPS`, 4, operands per line; must be ≥1.
- `W`, 4, operand width in bits, two's complement.
- `MAX_DIGITS`, 2, maximum decimal digits per operand; leading zeros count toward this limit.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received ASCII byte; valid only when `rx_valid`=1.
- `rx_valid` in 1: one byte accepted per cycle while high; back-to-back bytes are legal.
- `ops` out N_OPS*W: parsed frame. Operand k is at `ops[k*W +: W]`. Operand 0 is the first operand received.
- `ops_valid` out 1: one-cycle pulse when `ops` has just been updated with a complete frame.
- `err` out 1: one-cycle pulse on the first error in a line.
- `err_code` out 2: 0 BADCHAR, 1 DIGITS, 2 RANGE, 3 COUNT. Holds its last value until the next `err`.
- `busy` out 1: high while a line is partially parsed or being discarded.

## Operation
- Character classes:
  - digit 0x30–0x39
  - minus 0x2D
  - delimiter 0x20 or 0x2C
  - terminator 0x0A or 0x0D
  - anything else is BADCHAR
- State `IDLE` (between operands):
  - Delimiter: skip.
  - Minus: set `neg` and go to `SIGN`.
  - Digit: load the digit into `mag`, set `dcnt`=1, go to `DIGIT`.
  - Terminator with `idx`=0: ignore. This covers blank lines and the second byte of CR-LF.
  - Terminator with `idx`=N_OPS: publish the frame.
  - Terminator with any other `idx`: COUNT error.
- State `SIGN`:
  - Digit: go to `DIGIT`.
  - Any other byte: BADCHAR error.
- State `DIGIT`:
  - Digit: if `dcnt`=MAX_DIGITS, DIGITS error. Otherwise `mag`←`mag`*10+d; if `mag` exceeds the limit, RANGE error. DIGITS takes priority when both apply.
  - Delimiter: commit the operand and go to `IDLE`.
  - Terminator: commit the operand, then apply the `IDLE` terminator rule using the new `idx`.
  - Minus or any other byte: BADCHAR error.
- Range limit:
  - Positive operands: 2^(W-1)−1.
  - Negative operands: 2^(W-1).
  - Compute `mag` at a width sufficient for 10^MAX_DIGITS, so the comparison is never truncated.
- Commit:
  - If `idx`=N_OPS, COUNT error instead of storing.
  - Otherwise write `neg ? −mag : mag`, truncated to W bits, to working slot `idx`. Then `idx`++, clear `neg`, `mag` and `dcnt`.
- Publish:
  - Copy all working slots to `ops`, pulse `ops_valid`, clear `idx`, go to `IDLE`.
  - `ops` never shows a partial frame and holds its value between frames and across errors.
- Error:
  - Pulse `err`, load `err_code`, clear `idx`, `neg` and `mag`, go to `DISCARD`.
- State `DISCARD`:
  - Ignore every byte until a terminator, then go to `IDLE` with no pulse.
  - Exactly one `err` pulse is produced per bad line.
- `busy` = (state≠`IDLE`) | (`idx`≠0).
- Cycles with `rx_valid`=0 change no state. `ops_valid` and `err` are low in those cycles unless their pulse is due.

## Timing
- Reset (`reset`=0, asynchronous) sets:
  - `ops`=0, `ops_valid`=0, `err`=0, `err_code`=0, `busy`=0
  - state `IDLE`, `idx`=0
- Reset mid-line discards the partial line.
- Latency: a byte accepted at edge t produces its `ops_valid`/`err` pulse, `ops` update and `err_code` update in the cycle after edge t. All outputs are registered.
- `ops_valid` and `err` are never high in the same cycle.
- Throughput: one byte per cycle, with no stall output.

## Test plan
All scenarios use W=4, N_OPS=4, MAX_DIGITS=2.
- "1 -2 3 -4\n" back-to-back → single `ops_valid` the cycle after '\n'; `ops`=16'hC3E1; `err` never high.
- "7,-8,,0 5\r\n" with random `rx_valid` gaps → one `ops_valid` only, with the '\n' after '\r' ignored; `ops`=16'h5087.
- "8 1 2 3\n" → `err`, `err_code`=2 the cycle after '8'; no `ops_valid`; `ops` unchanged. Follow-up "-8 0 0 0\n" → `ops`=16'h0008.
- "007 1 1 1\n" → `err_code`=1 at the third '0'/'7' digit. Separately, "1 - 2 3 4\n" → `err_code`=0 at the space after '-'.
- "1 2 3\n" → `err_code`=3 at '\n'. Separately, "1 2 3 4 5\n" → `err_code`=3 at '\n'. In both, `busy` falls the cycle after '\n'.
- Assert `reset`=0 asynchronously after "1 2 " → all outputs 0 immediately. Then "3 3 3 3\n" → `ops`=16'h3333, `ops_valid` pulses once.
